// File: rtl/psys_route_pkg.sv
// Shared routing definitions: destination mode encodings and default stream widths.
package psys_route_pkg;

  localparam int unsigned G_W_DEF = 1280;
  localparam int unsigned H_W_DEF = 256;

  localparam logic [1:0] MODE_P0    = 2'd0;
  localparam logic [1:0] MODE_P1    = 2'd1;
  localparam logic [1:0] MODE_BCAST = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  // A programmed burst length of zero behaves as a single-beat burst.
  function automatic logic [15:0] eff_burst_len(input logic [15:0] burst_len);
    return (burst_len == 16'd0) ? 16'd1 : burst_len;
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-entry AXI-Stream output register; accepts a new beat when empty or draining.
module axis_out_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] in_data,
  input  logic             tready,
  output logic             tvalid,
  output logic [Width-1:0] tdata,
  output logic             can_accept
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Holding register: load wins over drain, data only changes on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (tready) begin
      valid_q <= 1'b0;
    end
  end

  // Space is available when empty or the held beat leaves this cycle.
  always_comb begin
    can_accept = !valid_q || tready;
  end

  assign tvalid = valid_q;
  assign tdata  = data_q;

endmodule

// File: rtl/in_switch_flex.sv
// Input switch: joins g/h streams (or passes h alone) and routes beats to one port,
// both ports, or alternating bursts across two ports.
module in_switch_flex
  import psys_route_pkg::*;
#(
  parameter int unsigned G_W = G_W_DEF,
  parameter int unsigned H_W = H_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [G_W-1:0]     s_axis_g_tdata,
  input  logic               s_axis_g_tvalid,
  output logic               s_axis_g_tready,
  input  logic [H_W-1:0]     s_axis_h_tdata,
  input  logic               s_axis_h_tvalid,
  output logic               s_axis_h_tready,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_join,
  input  logic [15:0]        cfg_burst_len,
  output logic [G_W+H_W-1:0] m_axis_tdata_0,
  output logic               m_axis_tvalid_0,
  input  logic               m_axis_tready_0,
  output logic [G_W+H_W-1:0] m_axis_tdata_1,
  output logic               m_axis_tvalid_1,
  input  logic               m_axis_tready_1,
  output logic [H_W-1:0]     m_axis_256_tdata_0,
  output logic               m_axis_256_tvalid_0,
  input  logic               m_axis_256_tready_0,
  output logic [H_W-1:0]     m_axis_256_tdata_1,
  output logic               m_axis_256_tvalid_1,
  input  logic               m_axis_256_tready_1
);

  localparam int unsigned J_W = G_W + H_W;

  logic [1:0]  mode_q;
  logic        join_q;
  logic [15:0] burst_q;
  logic [15:0] cnt_q;
  logic        ptr_q;

  logic        sel0, sel1;
  logic        acc_j0, acc_j1, acc_h0, acc_h1;
  logic        ok_j, ok_h, consume;
  logic        load_j0, load_j1, load_h0, load_h1;
  logic [J_W-1:0] beat_j;

  // Destination set from the current (registered) mode and alternate pointer.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    unique case (mode_q)
      MODE_P0:    sel0 = 1'b1;
      MODE_P1:    sel1 = 1'b1;
      MODE_BCAST: begin
        sel0 = 1'b1;
        sel1 = 1'b1;
      end
      MODE_ALT: begin
        sel0 = !ptr_q;
        sel1 = ptr_q;
      end
      default: ;
    endcase
  end

  // All-or-nothing consume: every selected register in the active group must accept.
  always_comb begin
    ok_j    = (!sel0 || acc_j0) && (!sel1 || acc_j1);
    ok_h    = (!sel0 || acc_h0) && (!sel1 || acc_h1);
    consume = rst_n && s_axis_h_tvalid && (join_q ? (s_axis_g_tvalid && ok_j) : ok_h);
    load_j0 = consume && join_q && sel0;
    load_j1 = consume && join_q && sel1;
    load_h0 = consume && !join_q && sel0;
    load_h1 = consume && !join_q && sel1;
    beat_j  = {s_axis_g_tdata, s_axis_h_tdata};
    s_axis_g_tready = consume && join_q;
    s_axis_h_tready = consume;
  end

  // Config latch and alternate-burst tracking; a load restarts the burst on port0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_P0;
      join_q  <= 1'b1;
      burst_q <= 16'd1;
      cnt_q   <= 16'd0;
      ptr_q   <= 1'b0;
    end else if (cfg_load) begin
      mode_q  <= cfg_mode;
      join_q  <= cfg_join;
      burst_q <= cfg_burst_len;
      cnt_q   <= 16'd0;
      ptr_q   <= 1'b0;
    end else if (consume && mode_q == MODE_ALT) begin
      if (cnt_q == eff_burst_len(burst_q) - 16'd1) begin
        cnt_q <= 16'd0;
        ptr_q <= !ptr_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  axis_out_slice #(.Width(J_W)) u_out_j0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_j0),
    .in_data    (beat_j),
    .tready     (m_axis_tready_0),
    .tvalid     (m_axis_tvalid_0),
    .tdata      (m_axis_tdata_0),
    .can_accept (acc_j0)
  );

  axis_out_slice #(.Width(J_W)) u_out_j1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_j1),
    .in_data    (beat_j),
    .tready     (m_axis_tready_1),
    .tvalid     (m_axis_tvalid_1),
    .tdata      (m_axis_tdata_1),
    .can_accept (acc_j1)
  );

  axis_out_slice #(.Width(H_W)) u_out_h0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_h0),
    .in_data    (s_axis_h_tdata),
    .tready     (m_axis_256_tready_0),
    .tvalid     (m_axis_256_tvalid_0),
    .tdata      (m_axis_256_tdata_0),
    .can_accept (acc_h0)
  );

  axis_out_slice #(.Width(H_W)) u_out_h1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_h1),
    .in_data    (s_axis_h_tdata),
    .tready     (m_axis_256_tready_1),
    .tvalid     (m_axis_256_tvalid_1),
    .tdata      (m_axis_256_tdata_1),
    .can_accept (acc_h1)
  );

endmodule

// File: tb/tb_in_switch_flex.sv
// Self-checking bench for in_switch_flex: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_in_switch_flex;
  import psys_route_pkg::*;

  localparam int GW = 1280;
  localparam int HW = 256;
  localparam int JW = 1536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [GW-1:0] s_axis_g_tdata;
  logic          s_axis_g_tvalid, s_axis_g_tready;
  logic [HW-1:0] s_axis_h_tdata;
  logic          s_axis_h_tvalid, s_axis_h_tready;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic          cfg_join;
  logic [15:0]   cfg_burst_len;
  logic [JW-1:0] m_axis_tdata_0, m_axis_tdata_1;
  logic          m_axis_tvalid_0, m_axis_tvalid_1;
  logic [HW-1:0] m_axis_256_tdata_0, m_axis_256_tdata_1;
  logic          m_axis_256_tvalid_0, m_axis_256_tvalid_1;
  logic [3:0]    rdy;
  logic [3:0]    tv;

  in_switch_flex dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_g_tdata      (s_axis_g_tdata),
    .s_axis_g_tvalid     (s_axis_g_tvalid),
    .s_axis_g_tready     (s_axis_g_tready),
    .s_axis_h_tdata      (s_axis_h_tdata),
    .s_axis_h_tvalid     (s_axis_h_tvalid),
    .s_axis_h_tready     (s_axis_h_tready),
    .cfg_load            (cfg_load),
    .cfg_mode            (cfg_mode),
    .cfg_join            (cfg_join),
    .cfg_burst_len       (cfg_burst_len),
    .m_axis_tdata_0      (m_axis_tdata_0),
    .m_axis_tvalid_0     (m_axis_tvalid_0),
    .m_axis_tready_0     (rdy[0]),
    .m_axis_tdata_1      (m_axis_tdata_1),
    .m_axis_tvalid_1     (m_axis_tvalid_1),
    .m_axis_tready_1     (rdy[1]),
    .m_axis_256_tdata_0  (m_axis_256_tdata_0),
    .m_axis_256_tvalid_0 (m_axis_256_tvalid_0),
    .m_axis_256_tready_0 (rdy[2]),
    .m_axis_256_tdata_1  (m_axis_256_tdata_1),
    .m_axis_256_tvalid_1 (m_axis_256_tvalid_1),
    .m_axis_256_tready_1 (rdy[3])
  );

  assign tv = {m_axis_256_tvalid_1, m_axis_256_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_0};

  int total = 0;
  int bad   = 0;

  // Model: config, beats consumed in alternate mode since the last load, port contents.
  int            m_mode;
  bit            m_join;
  int            m_burst;
  int            m_n;
  bit            occ[4];
  logic [JW-1:0] dat[4];
  logic [JW-1:0] logs[4][$];

  function automatic logic [JW-1:0] out_data(int p);
    case (p)
      0:       return m_axis_tdata_0;
      1:       return m_axis_tdata_1;
      2:       return JW'(m_axis_256_tdata_0);
      default: return JW'(m_axis_256_tdata_1);
    endcase
  endfunction

  task automatic chk(string name, logic [JW-1:0] act, logic [JW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_join = 1'b1; m_burst = 1; m_n = 0;
    for (int p = 0; p < 4; p++) begin
      occ[p] = 1'b0;
      dat[p] = '0;
    end
  endtask

  // One cycle: called at the falling edge with inputs already driven.
  task automatic step();
    logic [JW-1:0] beat;
    bit sel[2];
    bit ok, consume;
    int base, eff, ptr, grp;
    #1;
    eff  = (m_burst == 0) ? 1 : m_burst;
    ptr  = (m_n / eff) % 2;
    sel[0] = (m_mode == 0) || (m_mode == 2) || (m_mode == 3 && ptr == 0);
    sel[1] = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && ptr == 1);
    base = m_join ? 0 : 2;
    ok = 1'b1;
    for (int q = 0; q < 2; q++)
      if (sel[q] && occ[base+q] && !rdy[base+q]) ok = 1'b0;
    consume = rst_n && s_axis_h_tvalid && (!m_join || s_axis_g_tvalid) && ok;
    beat = m_join ? {s_axis_g_tdata, s_axis_h_tdata} : JW'(s_axis_h_tdata);
    chk("g_tready", JW'(s_axis_g_tready), JW'(consume && m_join));
    chk("h_tready", JW'(s_axis_h_tready), JW'(consume));
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("tvalid%0d", p), JW'(tv[p]), JW'(occ[p]));
      chk($sformatf("tdata%0d", p), out_data(p), dat[p]);
      if (tv[p] && rdy[p]) logs[p].push_back(out_data(p));
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int p = 0; p < 4; p++) begin
        grp = (p < 2) ? 0 : 2;
        if (consume && grp == base && sel[p%2]) begin
          occ[p] = 1'b1;
          dat[p] = (p < 2) ? beat : JW'(beat[HW-1:0]);
        end else if (rdy[p]) begin
          occ[p] = 1'b0;
        end
      end
      if (cfg_load) begin
        m_mode = int'(cfg_mode); m_join = cfg_join; m_burst = int'(cfg_burst_len); m_n = 0;
      end else if (consume && m_mode == 3) begin
        m_n++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_axis_g_tvalid = 1'b0; s_axis_h_tvalid = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic do_cfg(logic [1:0] mode, logic jn, logic [15:0] bl);
    idle_inputs();
    cfg_mode = mode; cfg_join = jn; cfg_burst_len = bl; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic flush();
    idle_inputs();
    rdy = 4'hF;
    repeat (3) step();
    for (int p = 0; p < 4; p++) logs[p].delete();
  endtask

  function automatic logic [JW-1:0] rnd_bits();
    logic [JW-1:0] v;
    for (int i = 0; i < JW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Feed n beats h=i, g=0 at full rate into the current config, then drain.
  task automatic feed_count(int n);
    rdy = 4'hF;
    for (int i = 0; i < n; i++) begin
      s_axis_g_tvalid = 1'b1; s_axis_h_tvalid = 1'b1;
      s_axis_g_tdata = '0; s_axis_h_tdata = HW'(i);
      step();
    end
    idle_inputs();
    repeat (3) step();
  endtask

  task automatic chk_log(string name, int p, int exp[$]);
    chk({name, "_len"}, JW'(logs[p].size()), JW'(exp.size()));
    for (int k = 0; k < exp.size() && k < logs[p].size(); k++)
      chk($sformatf("%s_%0d", name, k), logs[p][k], JW'(exp[k]));
  endtask

  logic [GW-1:0] pat_g;
  logic [HW-1:0] pat_h;
  logic [JW-1:0] tmp;

  initial begin
    rst_n = 1'b0; rdy = 4'h0; cfg_mode = 2'd0; cfg_join = 1'b0; cfg_burst_len = 16'd0;
    s_axis_g_tdata = '0; s_axis_h_tdata = '0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    repeat (2) step();
    chk("reset_tdata0", m_axis_tdata_0, '0);
    chk("reset_tvalid", JW'(tv), '0);
    rst_n = 1'b1;

    // Mode 0 join: {g,h} on port0 one cycle later, port1 silent.
    pat_g = {320{4'hA}}; pat_h = {64{4'h5}};
    rdy = 4'b0001;
    s_axis_g_tdata = pat_g; s_axis_h_tdata = pat_h;
    s_axis_g_tvalid = 1'b1; s_axis_h_tvalid = 1'b1;
    step();
    idle_inputs();
    #1;
    chk("join_p0_data", m_axis_tdata_0, {pat_g, pat_h});
    chk("join_p0_valid", JW'(m_axis_tvalid_0), JW'(1));
    chk("join_p1_valid", JW'(m_axis_tvalid_1), JW'(0));
    flush();

    // Broadcast with port1 stalled: input blocked until port1 frees, then both load.
    do_cfg(MODE_BCAST, 1'b1, 16'd1);
    rdy = 4'b0001;
    s_axis_g_tvalid = 1'b1; s_axis_h_tvalid = 1'b1;
    s_axis_g_tdata = '0; s_axis_h_tdata = HW'(11);
    step();
    s_axis_h_tdata = HW'(22);
    repeat (2) step();
    #1;
    chk("bcast_stall_g", JW'(s_axis_g_tready), JW'(0));
    chk("bcast_stall_h", JW'(s_axis_h_tready), JW'(0));
    rdy = 4'b0011;
    step();
    idle_inputs();
    #1;
    chk("bcast_p0", m_axis_tdata_0, JW'(22));
    chk("bcast_p1", m_axis_tdata_1, JW'(22));
    chk("bcast_v", JW'({m_axis_tvalid_1, m_axis_tvalid_0}), JW'(3));
    flush();

    // Alternate, burst 3, 8 beats.
    do_cfg(MODE_ALT, 1'b1, 16'd3);
    for (int p = 0; p < 4; p++) logs[p].delete();
    feed_count(8);
    chk_log("alt3_p0", 0, '{0, 1, 2, 6, 7});
    chk_log("alt3_p1", 1, '{3, 4, 5});
    flush();

    // Alternate, burst 0 behaves as 1.
    do_cfg(MODE_ALT, 1'b1, 16'd0);
    for (int p = 0; p < 4; p++) logs[p].delete();
    feed_count(4);
    chk_log("alt0_p0", 0, '{0, 2});
    chk_log("alt0_p1", 1, '{1, 3});
    flush();

    // Join with g missing: nothing moves until g arrives.
    do_cfg(MODE_P0, 1'b1, 16'd1);
    for (int p = 0; p < 4; p++) logs[p].delete();
    s_axis_h_tvalid = 1'b1; s_axis_h_tdata = HW'(77); s_axis_g_tdata = '0;
    repeat (5) step();
    chk("lone_h_len", JW'(logs[0].size()), JW'(0));
    s_axis_g_tvalid = 1'b1;
    step();
    idle_inputs();
    repeat (3) step();
    chk_log("lone_h_out", 0, '{77});
    flush();

    // h-only to port1, then reset mid-burst.
    do_cfg(MODE_P1, 1'b0, 16'd1);
    for (int p = 0; p < 4; p++) logs[p].delete();
    s_axis_g_tvalid = 1'b1; s_axis_h_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_h_tdata = HW'(100 + i);
      step();
    end
    chk("honly_first", logs[3].size() > 0 ? logs[3][0] : '1, JW'(100));
    rst_n = 1'b0;
    step();
    #1;
    chk("rst_tvalid", JW'(tv), '0);
    tmp = JW'(m_axis_256_tdata_1);
    chk("rst_tdata3", tmp, '0);
    rst_n = 1'b1;
    idle_inputs();
    step();

    // Randomized traffic, every cycle checked against the model.
    for (int c = 0; c < 4000; c++) begin
      cfg_load = ($urandom_range(0, 39) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_join = 1'($urandom_range(0, 1));
      cfg_burst_len = 16'($urandom_range(0, 4));
      s_axis_g_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_h_tvalid = ($urandom_range(0, 3) != 0);
      tmp = rnd_bits();
      s_axis_g_tdata = tmp[JW-1:HW];
      s_axis_h_tdata = tmp[HW-1:0];
      rdy = 4'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/in_switch_flex.md
IN_SWITCH_FLEX -- requirements
Module: in_switch_flex

Interface
REQ-001 SHALL have parameter G_W, default 1280: width of the g stream.
REQ-002 SHALL have parameter H_W, default 256: width of the h stream; the joined width is G_W+H_W = 1536.
REQ-003 SHALL have clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have s_axis_g_tdata/tvalid/tready, in/in/out, G_W/1/1: g slave stream.
REQ-006 SHALL have s_axis_h_tdata/tvalid/tready, in/in/out, H_W/1/1: h slave stream.
REQ-007 SHALL have cfg_load, input, 1: one-cycle pulse that latches cfg_mode, cfg_join and cfg_burst_len.
REQ-008 SHALL have cfg_mode, input, 2: destination select. 0 = port0, 1 = port1, 2 = broadcast, 3 = alternate.
REQ-009 SHALL have cfg_join, input, 1: 1 = joined 1536-bit beats; 0 = h-only 256-bit beats.
REQ-010 SHALL have cfg_burst_len, input, 16: beats per port in alternate mode.
REQ-011 SHALL have m_axis_tdata_N/tvalid_N/tready_N, out/out/in, 1536/1/1, for N = 0 and 1: joined master ports.
REQ-012 SHALL have m_axis_256_tdata_N/tvalid_N/tready_N, out/out/in, H_W/1/1, for N = 0 and 1: h-only master ports.

Function
REQ-013 SHALL give every master port a one-entry output register. The register accepts a new beat when !tvalid || tready. Latency from input handshake to tvalid is 1 cycle.
REQ-014 In join mode, SHALL form the beat as {g[1279:0], h[255:0]}, with g in bits [1535:256]. g and h SHALL be consumed in the same cycle, only when both tvalid are high and every selected destination can accept.
REQ-015 In join mode, s_axis_g_tready and s_axis_h_tready SHALL both be 1 exactly in the consume cycle. They SHALL be 0 otherwise, so a lone valid g or lone valid h is never consumed.
REQ-016 In h-only mode, SHALL route h to the m_axis_256 ports. s_axis_g_tready SHALL be 0.
REQ-017 Destination set, per mode:
- mode 0: port0 only.
- mode 1: port1 only.
- mode 2: both ports. The input SHALL be consumed only when both selected registers can accept, and both SHALL load in the same cycle; there is no partial delivery.
- mode 3: the port given by ptr.
REQ-018 Alternate mode: a 16-bit beat counter SHALL increment per consumed beat.
- When the count reaches burst_len-1, the counter SHALL clear and ptr SHALL toggle.
- A burst_len of 0 SHALL be treated as 1.
REQ-019 On cfg_load, SHALL latch the config, clear the counter, and set ptr = 0. The new config takes effect from the next cycle. Beats already in output registers SHALL drain unchanged. A beat consumed in the cfg_load cycle SHALL use the old config.
REQ-020 Unselected output registers SHALL hold their contents; tdata SHALL NOT change while tvalid && !tready.
REQ-021 SHALL sustain 1 beat/cycle per destination when its tready is held at 1.

Reset
REQ-022 While rst_n is 0, every output tdata, all tvalid outputs, the counter and ptr SHALL be 0, and config SHALL reset to mode 0, join 1, burst_len 1.
REQ-023 Every input tready SHALL be 0 during reset. Reset applied mid-transfer SHALL drop pending output beats.

Structure
REQ-024 Mode encodings (MODE_P0, MODE_P1, MODE_BCAST, MODE_ALT) and G_W/H_W defaults SHALL live in shared package psys_route_pkg.
REQ-025 The per-port output register SHALL be one sub-module, axis_out_slice (parameter width), instantiated four times.

Verification
REQ-026 Mode 0, join: g=0xA..A, h=0x5..5 both valid, tready_0=1 -> m_axis_tdata_0={g,h} one cycle later; port1 tvalid stays 0.
REQ-027 Mode 2, tready_0=1, tready_1=0 with both registers full -> both input treadys 0. Raise tready_1 -> both ports load the next beat in the same cycle.
REQ-028 Mode 3, burst_len=3, 8 beats with values 0..7 -> port0 gets 0,1,2,6,7; port1 gets 3,4,5.
REQ-029 Join, h valid, g low for 5 cycles -> no consumption and no output. Raise g -> single beat out.
REQ-030 h-only mode, mode 1 -> h beats appear on m_axis_256_tdata_1, g tready 0. Apply rst_n=0 mid-burst -> all tvalid 0 on the next cycle.
REQ-031 Mode 3, burst_len=0 -> ptr toggles every beat.
